// File: rtl/vp_pixel_serializer.sv
// Pixel serializer: one styled character row in, one colour index per pixel out, MSB first.
// Define VP_PIXEL_SERIALIZER_DOUBLE_EN to add the double_width port (each pixel held two cycles).
module vp_pixel_serializer #(
  parameter int CHAR_WIDTH = 16,
  parameter int COLOR_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COLOR_BITS-1:0] txt_foreground,
  input  logic [COLOR_BITS-1:0] txt_background,
  input  logic [CHAR_WIDTH-1:0] txt_bitmap,
  input  logic                  enable,
  output logic                  ready,
  input  logic                  flush,
`ifdef VP_PIXEL_SERIALIZER_DOUBLE_EN
  input  logic                  double_width,
`endif
  output logic [COLOR_BITS-1:0] pixel_color,
  output logic                  pixel_valid,
  output logic                  underrun
);

  localparam int CNT_W = $clog2(CHAR_WIDTH) + 1;

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t                  state, state_next;
  logic                    pend_valid;
  logic [CHAR_WIDTH-1:0]   pend_bitmap;
  logic [COLOR_BITS-1:0]   pend_fg, pend_bg;
  logic [CHAR_WIDTH-1:0]   shift_bitmap;
  logic [COLOR_BITS-1:0]   shift_fg, shift_bg;
  logic [CNT_W-1:0]        count;
  logic                    half;
  logic                    wide;
  logic                    dry;
  logic                    dw_in;
  logic                    take, step, last, load;

`ifdef VP_PIXEL_SERIALIZER_DOUBLE_EN
  assign dw_in = double_width;
`else
  assign dw_in = 1'b0;
`endif

  assign ready = ~pend_valid;

  always_comb begin
    state_next = state;
    take       = enable && !pend_valid && !flush;
    // in wide mode a pixel only advances on its second cycle
    step       = (state == SHIFT) && (!wide || half);
    last       = step && (count == CNT_W'(CHAR_WIDTH - 1));
    load       = pend_valid && ((state == IDLE) || last);
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (pend_valid) state_next = SHIFT;
        SHIFT:   if (last && !pend_valid) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_valid   <= 1'b0;
      pend_bitmap  <= '0;
      pend_fg      <= '0;
      pend_bg      <= '0;
      shift_bitmap <= '0;
      shift_fg     <= '0;
      shift_bg     <= '0;
      count        <= '0;
      half         <= 1'b0;
      wide         <= 1'b0;
      dry          <= 1'b0;
      pixel_color  <= '0;
      pixel_valid  <= 1'b0;
      underrun     <= 1'b0;
    end else if (flush) begin
      pend_valid  <= 1'b0;
      half        <= 1'b0;
      dry         <= 1'b0;
      pixel_color <= '0;
      pixel_valid <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      underrun <= dry;
      dry      <= last && !pend_valid;

      if (take) begin
        pend_valid  <= 1'b1;
        pend_bitmap <= txt_bitmap;
        pend_fg     <= txt_foreground;
        pend_bg     <= txt_background;
      end else if (load) begin
        pend_valid <= 1'b0;
      end

      if (state == SHIFT) begin
        pixel_valid <= 1'b1;
        pixel_color <= shift_bitmap[CHAR_WIDTH-1] ? shift_fg : shift_bg;
      end else begin
        pixel_valid <= 1'b0;
        pixel_color <= '0;
      end

      if (load) begin
        shift_bitmap <= pend_bitmap;
        shift_fg     <= pend_fg;
        shift_bg     <= pend_bg;
        count        <= '0;
        half         <= 1'b0;
        wide         <= dw_in;
      end else if (state == SHIFT) begin
        if (wide && !half) begin
          half <= 1'b1;
        end else begin
          half         <= 1'b0;
          shift_bitmap <= shift_bitmap << 1;
          count        <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vp_pixel_serializer.sv
// Directed bench for vp_pixel_serializer: reset, streaming, back-to-back, flush, busy-input rejection.
module tb_vp_pixel_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  txt_foreground, txt_background;
  logic [15:0] txt_bitmap;
  logic        enable, flush, double_width;
  logic        ready, pixel_valid, underrun;
  logic [3:0]  pixel_color;

  int tests = 0;
  int fails = 0;

  vp_pixel_serializer dut (
    .clk           (clk),
    .reset         (reset),
    .txt_foreground(txt_foreground),
    .txt_background(txt_background),
    .txt_bitmap    (txt_bitmap),
    .enable        (enable),
    .ready         (ready),
    .flush         (flush),
`ifdef VP_PIXEL_SERIALIZER_DOUBLE_EN
    .double_width  (double_width),
`endif
    .pixel_color   (pixel_color),
    .pixel_valid   (pixel_valid),
    .underrun      (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] bm, input logic [3:0] fg, input logic [3:0] bg);
    txt_bitmap     = bm;
    txt_foreground = fg;
    txt_background = bg;
  endtask

  task automatic check_pix(input string tag, input logic v, input logic [3:0] c, input logic u);
    check({tag, ".valid"}, pixel_valid, v);
    check({tag, ".color"}, pixel_color, c);
    check({tag, ".underrun"}, underrun, u);
  endtask

  function automatic logic [3:0] pix(input logic [15:0] bm, input logic [3:0] fg,
                                     input logic [3:0] bg, input int k);
    return bm[15-k] ? fg : bg;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; flush = 1'b0; double_width = 1'b0;
    drive(16'h0, 4'h0, 4'h0);
    tick(); tick();
    check_pix("reset", 1'b0, 4'h0, 1'b0);
    check("reset.ready", ready, 1'b1);
    reset = 1'b1;
    tick();

    // mid-stream reset
    drive(16'hFFFF, 4'h7, 4'h0); enable = 1'b1;
    tick(); enable = 1'b0;
    repeat (5) tick();
    check("pre_reset.valid", pixel_valid, 1'b1);
    reset = 1'b0;
    tick(); check_pix("mid_reset1", 1'b0, 4'h0, 1'b0); check("mid_reset1.ready", ready, 1'b1);
    tick(); check_pix("mid_reset2", 1'b0, 4'h0, 1'b0); check("mid_reset2.ready", ready, 1'b1);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(); check_pix("post_reset", 1'b0, 4'h0, 1'b0);
    end

    // single character, latency and underrun
    drive(16'h8001, 4'hF, 4'h1); enable = 1'b1;
    check("t2.ready0", ready, 1'b1);
    tick(); enable = 1'b0;                       // edge 0
    check("t2.ready_full", ready, 1'b0);
    tick(); check_pix("t2.e1", 1'b0, 4'h0, 1'b0); // edge 1
    for (int k = 0; k < 16; k++) begin
      tick(); check_pix("t2.pix", 1'b1, (k == 0 || k == 15) ? 4'hF : 4'h1, 1'b0);
    end
    tick(); check_pix("t2.e18", 1'b0, 4'h0, 1'b1);
    tick(); check_pix("t2.e19", 1'b0, 4'h0, 1'b0);
    repeat (3) tick();

    // back-to-back characters with enable held
    drive(16'hFFFF, 4'h3, 4'h0); enable = 1'b1;
    tick();                                      // edge 0
    check("t3.ready_e0", ready, 1'b0);
    drive(16'h0000, 4'h0, 4'h5);
    tick(); check("t3.ready_e1", ready, 1'b1);   // edge 1
    tick(); enable = 1'b0;                       // edge 2
    check("t3.ready_e2", ready, 1'b0);
    check_pix("t3.e2", 1'b1, 4'h3, 1'b0);
    for (int e = 3; e <= 35; e++) begin
      tick();
      if (e <= 17)      check_pix("t3.a", 1'b1, 4'h3, 1'b0);
      else if (e <= 33) check_pix("t3.b", 1'b1, 4'h5, 1'b0);
      else if (e == 34) check_pix("t3.e34", 1'b0, 4'h0, 1'b1);
      else              check_pix("t3.e35", 1'b0, 4'h0, 1'b0);
      if (e == 16) check("t3.ready_e16", ready, 1'b0);
      if (e == 17) check("t3.ready_e17", ready, 1'b1);
    end
    repeat (3) tick();

    // flush at pixel 7 with a character pending
    drive(16'hAAAA, 4'h9, 4'h2); enable = 1'b1;
    tick(); enable = 1'b0;                       // edge 0
    tick();                                      // edge 1
    drive(16'h5555, 4'hC, 4'hD); enable = 1'b1;
    tick(); enable = 1'b0;                       // edge 2, pixel 0
    check_pix("t4.p0", 1'b1, 4'h9, 1'b0);
    repeat (7) tick();                           // edge 9, pixel 7
    check_pix("t4.p7", 1'b1, 4'h2, 1'b0);
    check("t4.ready_p7", ready, 1'b0);
    flush = 1'b1; enable = 1'b1; drive(16'h1234, 4'hE, 4'hE);
    tick(); flush = 1'b0; enable = 1'b0;         // edge 10
    check_pix("t4.flush", 1'b0, 4'h0, 1'b0);
    check("t4.ready_flush", ready, 1'b1);
    for (int i = 0; i < 25; i++) begin
      tick(); check_pix("t4.after", 1'b0, 4'h0, 1'b0);
    end

    // enable while busy must not disturb accepted data
    drive(16'h00FF, 4'h6, 4'h8); enable = 1'b1;
    tick();                                      // edge 0
    drive(16'h1357, 4'hE, 4'hE);
    tick();                                      // edge 1, ignored (pending full)
    drive(16'hF00F, 4'h1, 4'h2);
    tick();                                      // edge 2, accepted
    check_pix("t5.e2", 1'b1, pix(16'h00FF, 4'h6, 4'h8, 0), 1'b0);
    drive(16'h0F0F, 4'hE, 4'hE);
    for (int e = 3; e <= 34; e++) begin
      if (e == 17) enable = 1'b0;
      tick();
      if (e <= 17)      check_pix("t5.a", 1'b1, pix(16'h00FF, 4'h6, 4'h8, e - 2), 1'b0);
      else if (e <= 33) check_pix("t5.b", 1'b1, pix(16'hF00F, 4'h1, 4'h2, e - 18), 1'b0);
      else              check_pix("t5.e34", 1'b0, 4'h0, 1'b1);
    end
    enable = 1'b0;
    repeat (3) tick();
    check("t5.ready_end", ready, 1'b1);

`ifdef VP_PIXEL_SERIALIZER_DOUBLE_EN
    // double width: each pixel held two cycles
    drive(16'hA000, 4'hF, 4'h0); double_width = 1'b1; enable = 1'b1;
    tick(); enable = 1'b0;                       // edge 0
    tick(); double_width = 1'b0;                 // edge 1, loaded
    for (int e = 2; e <= 35; e++) begin
      tick();
      if (e <= 33)      check_pix("t6.pix", 1'b1, pix(16'hA000, 4'hF, 4'h0, (e - 2) / 2), 1'b0);
      else if (e == 34) check_pix("t6.e34", 1'b0, 4'h0, 1'b1);
      else              check_pix("t6.e35", 1'b0, 4'h0, 1'b0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
